// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the pipelined add/subtract unit.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;

    // Width of one carry-chain slice; WIDTH is expected to divide evenly by STAGES.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The master drives operations and accepts results; the slave is the adder.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             sub;
    logic             valid_out;
    logic             ready_out;
    logic [WIDTH-1:0] Sum_out;
    logic             carry_out;
    logic             overflow;

    modport master (
        output valid_in, in_1, in_2, sub, ready_out,
        input  ready_in, valid_out, Sum_out, carry_out, overflow
    );

    modport slave (
        input  valid_in, in_1, in_2, sub, ready_out,
        output ready_in, valid_out, Sum_out, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_adder_slice.sv
// One SW-bit slice of the carry chain. It also exposes the operand sign bits
// so the top slice can form the signed-overflow term.
module adder_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          a_sign,
    output logic          b_sign
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign a_sign    = a[SW-1];
    assign b_sign    = b[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
// slices; stage k adds slice k and registers it together with the completed
// lower sum slices and the still-unprocessed upper operand slices, so the
// full result leaves the last stage aligned. One global advance signal moves
// every stage at once, which keeps the handshake simple and order-preserving.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_adder_if.slave   bus
);

    localparam int SW = slice_width(WIDTH, STAGES);

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_eff;

    // The pipeline moves whenever the output slot is empty or being drained.
    assign adv          = !bus.valid_out || bus.ready_out;
    assign bus.ready_in = adv;
    assign accept       = bus.valid_in && adv;

    // Subtraction is A + ~B + 1: invert B here, inject the +1 as stage-0 carry-in.
    assign b_eff = bus.sub ? ~bus.in_2 : bus.in_2;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = LO + SW;

        // Inputs to this stage: valid, carry, accumulator (sum below LO,
        // raw A at and above LO) and the remaining B' bits starting at LO.
        logic                v_prev;
        logic                c_prev;
        logic [WIDTH-1:0]    acc_prev;
        logic [WIDTH-LO-1:0] b_prev;

        logic [SW-1:0]       s_sl;
        logic                c_sl;
        logic                a_sign;
        logic                b_sign;
        logic [WIDTH-1:0]    acc_d;

        logic                v_q;
        logic                c_q;
        logic [WIDTH-1:0]    acc_q;

        if (k == 0) begin : g_src
            assign v_prev   = accept;
            assign c_prev   = bus.sub;
            assign acc_prev = bus.in_1;
            assign b_prev   = b_eff;
        end else begin : g_src
            assign v_prev   = g_stage[k-1].v_q;
            assign c_prev   = g_stage[k-1].c_q;
            assign acc_prev = g_stage[k-1].acc_q;
            assign b_prev   = g_stage[k-1].g_rem.b_q;
        end

        adder_slice #(.SW(SW)) u_slice (
            .a      (acc_prev[LO +: SW]),
            .b      (b_prev[SW-1:0]),
            .cin    (c_prev),
            .s      (s_sl),
            .cout   (c_sl),
            .a_sign (a_sign),
            .b_sign (b_sign)
        );

        // Replace this stage's A slice in the accumulator with its sum slice.
        always_comb begin
            // NOTE: full default before the partial overwrite, so no bit is left unassigned (no latch).
            acc_d           = acc_prev;
            acc_d[LO +: SW] = s_sl;
        end

        // Stage register: valid follows upstream on advance; data loads only
        // with a valid op, so idle (possibly X) inputs never reach the outputs.
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: state is updated with <= so every stage samples the pre-edge value of its neighbour.
            if (rst) begin
                // NOTE: data registers are reset too, because Sum_out and flags must read 0 after reset.
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else if (adv) begin
                v_q <= v_prev;
                if (v_prev) begin
                    c_q   <= c_sl;
                    acc_q <= acc_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [WIDTH-HI-1:0] b_q;
            // Sign bits only matter at the top slice.
            logic                unused_signs;

            assign unused_signs = a_sign ^ b_sign;

            // Carry the still-unprocessed B' slices alongside the accumulator.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_q <= '0;
                end else if (adv && v_prev) begin
                    b_q <= b_prev[WIDTH-LO-1:SW];
                end
            end
        end else begin : g_out
            logic ov_q;

            // Signed overflow: operands agree in sign but the result does not.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else if (adv && v_prev) begin
                    ov_q <= (a_sign == b_sign) && (s_sl[SW-1] != a_sign);
                end
            end

            assign bus.valid_out = v_q;
            assign bus.Sum_out   = acc_q;
            assign bus.carry_out = c_q;
            assign bus.overflow  = ov_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a WIDTH=32/STAGES=2 instance for the
// handshake, latency, stall and reset scenarios, plus STAGES=1/4/8 instances
// swept against a reference arithmetic model.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int NV = 5;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipelined_adder_if #(.WIDTH(W)) bus2 ();
    pipelined_adder_if #(.WIDTH(W)) bus1 ();
    pipelined_adder_if #(.WIDTH(W)) bus4 ();
    pipelined_adder_if #(.WIDTH(W)) bus8 ();

    pipelined_adder #(.WIDTH(W), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    pipelined_adder #(.WIDTH(W), .STAGES(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
    } vec_t;

    vec_t sweep_vec [NV];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        longint       sa = longint'($signed(a));
        longint       sb = longint'($signed(b));
        longint       sr;
        logic [W:0]   ur;
        logic         c;
        logic         v;
        ur = {1'b0, a} + {1'b0, b};
        sr = s ? (sa - sb) : (sa + sb);
        c  = s ? (a >= b) : ur[W];
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, c, sr[W-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        bus2.valid_in = v;
        bus2.in_1     = v ? a : 'x;
        bus2.in_2     = v ? b : 'x;
        bus2.sub      = v ? s : 1'bx;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] sum, input logic c,
                              input logic v);
        check({tag, "_valid"}, bus2.valid_out, 1'b1);
        check({tag, "_sum"},   bus2.Sum_out,   sum);
        check({tag, "_carry"}, bus2.carry_out, c);
        check({tag, "_ovf"},   bus2.overflow,  v);
    endtask

    // One isolated op on the STAGES=2 instance: not visible after one edge,
    // complete after two, gone after the drain edge.
    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] sum, input logic c,
                          input logic v);
        drive(1'b1, a, b, s);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check({tag, "_early"}, bus2.valid_out, 1'b0);
        tick();
        expect_res(tag, sum, c, v);
        tick();
        check({tag, "_drain"}, bus2.valid_out, 1'b0);
    endtask

    task automatic drive_sweep(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
        bus1.valid_in = v; bus1.in_1 = v ? a : 'x; bus1.in_2 = v ? b : 'x; bus1.sub = v ? s : 1'bx;
        bus4.valid_in = v; bus4.in_1 = v ? a : 'x; bus4.in_2 = v ? b : 'x; bus4.sub = v ? s : 1'bx;
        bus8.valid_in = v; bus8.in_1 = v ? a : 'x; bus8.in_2 = v ? b : 'x; bus8.sub = v ? s : 1'bx;
    endtask

    // After edge i, a STAGES=st instance shows the vector accepted at edge i-st+1.
    task automatic check_one(input string tag, input int st, input int i, input logic vo,
                             input logic [W-1:0] so, input logic co, input logic ovo);
        int          idx = i - st + 1;
        logic        exp_v = (idx >= 0) && (idx < NV);
        logic [W+1:0] r;
        check($sformatf("%s_valid_%0d", tag, i), vo, exp_v);
        if (exp_v) begin
            r = model(sweep_vec[idx].a, sweep_vec[idx].b, sweep_vec[idx].s);
            check($sformatf("%s_sum_%0d", tag, i),   so,  r[W-1:0]);
            check($sformatf("%s_carry_%0d", tag, i), co,  r[W]);
            check($sformatf("%s_ovf_%0d", tag, i),   ovo, r[W+1]);
        end
    endtask

    initial begin
        sweep_vec[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, s: 1'b0};
        sweep_vec[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, s: 1'b0};
        sweep_vec[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, s: 1'b1};
        sweep_vec[3] = '{a: 32'h0F0F_0F0F, b: 32'h1010_1010, s: 1'b1};
        sweep_vec[4] = '{a: 32'hDEAD_BEEF, b: 32'h2152_4111, s: 1'b0};

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        bus2.ready_out = 1'b1;
        drive_sweep(1'b0, '0, '0, 1'b0);
        bus1.ready_out = 1'b1;
        bus4.ready_out = 1'b1;
        bus8.ready_out = 1'b1;

        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_valid_out", bus2.valid_out, 1'b0);
        check("rst_ready_in",  bus2.ready_in,  1'b1);
        check("rst_sum",       bus2.Sum_out,   32'h0);
        check("rst_carry",     bus2.carry_out, 1'b0);
        check("rst_ovf",       bus2.overflow,  1'b0);
        tick();

        // Single ops: zero, carry across the slice boundary, signed overflow, subtract.
        single("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        single("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("plain",    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        single("sub_neg",  32'd10,        32'd20,        1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0);
        single("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream with a three-cycle downstream stall.
        drive(1'b1, 32'd1, 32'd2, 1'b0);
        tick();
        drive(1'b1, 32'h100, 32'h200, 1'b0);
        tick();
        expect_res("b2b_op0", 32'd3, 1'b0, 1'b0);
        drive(1'b1, 32'd5, 32'd3, 1'b1);
        tick();
        expect_res("b2b_op1", 32'h300, 1'b0, 1'b0);
        bus2.ready_out = 1'b0;
        drive(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        #1;
        check("stall_ready_in_pre", bus2.ready_in, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_res($sformatf("stall_hold_%0d", i), 32'h300, 1'b0, 1'b0);
            check($sformatf("stall_ready_in_%0d", i), bus2.ready_in, 1'b0);
        end
        bus2.ready_out = 1'b1;
        tick();
        expect_res("b2b_op2", 32'd2, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        expect_res("b2b_op3", 32'h0, 1'b1, 1'b0);
        tick();
        check("b2b_drain", bus2.valid_out, 1'b0);

        // Reset with two operations in flight.
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("inflight_valid_before_rst", bus2.valid_out, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid_out", bus2.valid_out, 1'b0);
        check("mid_rst_sum",       bus2.Sum_out,   32'h0);
        check("mid_rst_carry",     bus2.carry_out, 1'b0);
        check("mid_rst_ovf",       bus2.overflow,  1'b0);
        check("mid_rst_ready_in",  bus2.ready_in,  1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_discard_%0d", i), bus2.valid_out, 1'b0);
        end

        // Depth sweep: back-to-back stream into STAGES=1/4/8 with idle X data afterwards.
        for (int i = 0; i < NV + 8; i++) begin
            if (i < NV) drive_sweep(1'b1, sweep_vec[i].a, sweep_vec[i].b, sweep_vec[i].s);
            else        drive_sweep(1'b0, '0, '0, 1'b0);
            tick();
            check_one("s1", 1, i, bus1.valid_out, bus1.Sum_out, bus1.carry_out, bus1.overflow);
            check_one("s4", 4, i, bus4.valid_out, bus4.Sum_out, bus4.carry_out, bus4.overflow);
            check_one("s8", 8, i, bus8.valid_out, bus8.Sum_out, bus8.carry_out, bus8.overflow);
        end
        check("s1_no_x", $isunknown({bus1.Sum_out, bus1.carry_out, bus1.overflow}), 1'b0);
        check("s4_no_x", $isunknown({bus4.Sum_out, bus4.carry_out, bus4.overflow}), 1'b0);
        check("s8_no_x", $isunknown({bus8.Sum_out, bus8.carry_out, bus8.overflow}), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
